// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
// Arbitrates the data-side and instruction-fetch uncached requesters onto one AXI4 master.
// Each grant becomes exactly one single-beat AXI transaction (read or write); the granted
// requester sees a one-cycle finish pulse, with read data valid in that same cycle.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   data_*                         data-side requester (level we/re, addr, wdata, mask)
//   data_rdata / data_finish       data-side response
//   inst_addr / inst_re            fetch requester (read only)
//   inst_rdata / inst_finish       fetch response
//   aw* / w* / b* / ar* / r*       AXI4 master, single beat, registered outputs
//   bus_err                        one-cycle pulse alongside finish on nonzero rresp/bresp
module axi_mem_arbiter #(
  parameter logic [3:0]  AXI_ID = 4'd0,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Data-side requester
  input  logic [63:0]       data_addr,
  input  logic [63:0]       data_wdata,
  input  logic [7:0]        data_mask,
  input  logic              data_we,
  input  logic              data_re,
  output logic [63:0]       data_rdata,
  output logic              data_finish,
  // Instruction-fetch requester
  input  logic [63:0]       inst_addr,
  input  logic              inst_re,
  output logic [63:0]       inst_rdata,
  output logic              inst_finish,
  // AXI write address channel
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awid,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  // AXI write data channel
  output logic              wvalid,
  input  logic              wready,
  output logic [63:0]       wdata,
  output logic [7:0]        wstrb,
  output logic              wlast,
  // AXI write response channel
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  // AXI read address channel
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  // AXI read data channel
  input  logic              rvalid,
  output logic              rready,
  input  logic [63:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  // Error pulse
  output logic              bus_err
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAww, StB} state_e;

  state_e              state_q, state_d;
  logic                last_grant_inst_q, last_grant_inst_d;
  logic                req_inst_q, req_inst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [7:0]          mask_q, mask_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [63:0]         data_rdata_q, data_rdata_d;
  logic [63:0]         inst_rdata_q, inst_rdata_d;
  logic                data_finish_q, data_finish_d;
  logic                inst_finish_q, inst_finish_d;
  logic                bus_err_q, bus_err_d;

  logic                data_req;
  logic                grant_inst;
  logic                grant_write;

  // rlast is meaningless for single-beat reads; upper address bits are truncated.
  logic                unused_ok;
  assign unused_ok = ^{rlast, data_addr, inst_addr};

  always_comb begin
    state_d           = state_q;
    last_grant_inst_d = last_grant_inst_q;
    req_inst_d        = req_inst_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    mask_d            = mask_q;
    awvalid_d         = awvalid_q;
    wvalid_d          = wvalid_q;
    bready_d          = bready_q;
    arvalid_d         = arvalid_q;
    rready_d          = rready_q;
    data_rdata_d      = data_rdata_q;
    inst_rdata_d      = inst_rdata_q;
    data_finish_d     = 1'b0;
    inst_finish_d     = 1'b0;
    bus_err_d         = 1'b0;

    data_req    = data_we | data_re;
    // Fetch wins when it is alone, or when both request and data won last time.
    grant_inst  = inst_re & (~data_req | ~last_grant_inst_q);
    // A data grant with we set is a write even if re is also set.
    grant_write = ~grant_inst & data_we;

    unique case (state_q)
      StIdle: begin
        if (data_req || inst_re) begin
          last_grant_inst_d = grant_inst;
          req_inst_d        = grant_inst;
          addr_d            = grant_inst ? inst_addr[ADDR_W-1:0] : data_addr[ADDR_W-1:0];
          wdata_d           = data_wdata;
          mask_d            = data_mask;
          if (grant_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StAww;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StAr;
          end
        end
      end

      StAr: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StR;
        end
      end

      StR: begin
        if (rvalid) begin
          rready_d  = 1'b0;
          bus_err_d = (rresp != 2'b00);
          if (req_inst_q) begin
            inst_rdata_d  = rdata;
            inst_finish_d = 1'b1;
          end else begin
            data_rdata_d  = rdata;
            data_finish_d = 1'b1;
          end
          state_d = StIdle;
        end
      end

      StAww: begin
        // AW and W retire independently; move on once neither is still pending.
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          bready_d = 1'b1;
          state_d  = StB;
        end
      end

      StB: begin
        if (bvalid) begin
          bready_d      = 1'b0;
          bus_err_d     = (bresp != 2'b00);
          data_finish_d = 1'b1;
          state_d       = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      last_grant_inst_q <= 1'b1;
      req_inst_q        <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      mask_q            <= '0;
      awvalid_q         <= 1'b0;
      wvalid_q          <= 1'b0;
      bready_q          <= 1'b0;
      arvalid_q         <= 1'b0;
      rready_q          <= 1'b0;
      data_rdata_q      <= '0;
      inst_rdata_q      <= '0;
      data_finish_q     <= 1'b0;
      inst_finish_q     <= 1'b0;
      bus_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_inst_q <= last_grant_inst_d;
      req_inst_q        <= req_inst_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      mask_q            <= mask_d;
      awvalid_q         <= awvalid_d;
      wvalid_q          <= wvalid_d;
      bready_q          <= bready_d;
      arvalid_q         <= arvalid_d;
      rready_q          <= rready_d;
      data_rdata_q      <= data_rdata_d;
      inst_rdata_q      <= inst_rdata_d;
      data_finish_q     <= data_finish_d;
      inst_finish_q     <= inst_finish_d;
      bus_err_q         <= bus_err_d;
    end
  end

  assign data_rdata  = data_rdata_q;
  assign data_finish = data_finish_q;
  assign inst_rdata  = inst_rdata_q;
  assign inst_finish = inst_finish_q;
  assign bus_err     = bus_err_q;

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = 3'b011;
  assign awburst = 2'b01;

  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = mask_q;
  assign wlast   = wvalid_q;

  assign bready  = bready_q;

  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b011;
  assign arburst = 2'b01;

  assign rready  = rready_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
module tb_axi_mem_arbiter;

  logic        clk, rst;
  logic [63:0] data_addr, data_wdata, data_rdata;
  logic [7:0]  data_mask;
  logic        data_we, data_re, data_finish;
  logic [63:0] inst_addr, inst_rdata;
  logic        inst_re, inst_finish;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;
  logic        arvalid, arready, rvalid, rready, rlast, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  axi_mem_arbiter #(.AXI_ID(4'd0), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_mask(data_mask),
    .data_we(data_we), .data_re(data_re), .data_rdata(data_rdata), .data_finish(data_finish),
    .inst_addr(inst_addr), .inst_re(inst_re), .inst_rdata(inst_rdata),
    .inst_finish(inst_finish),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the request already driven and the DUT idle. Returns at the
  // negedge of the finish cycle with rvalid dropped; caller updates its request there.
  task automatic read_txn(input string tag, input logic [63:0] exp_addr,
                          input logic [63:0] rd, input logic [1:0] resp, input logic inst);
    @(negedge clk);
    chk({tag, "_arvalid"}, {63'd0, arvalid}, 64'd1);
    chk({tag, "_araddr"}, {32'd0, araddr}, exp_addr);
    @(negedge clk);
    chk({tag, "_rready"}, {63'd0, rready}, 64'd1);
    rvalid = 1'b1;
    rdata  = rd;
    rresp  = resp;
    @(negedge clk);
    rvalid = 1'b0;
    rresp  = 2'b00;
    chk({tag, "_data_finish"}, {63'd0, data_finish}, {63'd0, ~inst});
    chk({tag, "_inst_finish"}, {63'd0, inst_finish}, {63'd0, inst});
    chk({tag, "_rdata"}, inst ? inst_rdata : data_rdata, rd);
    chk({tag, "_bus_err"}, {63'd0, bus_err}, {63'd0, resp != 2'b00});
  endtask

  initial begin
    rst = 1'b1;
    data_addr = '0; data_wdata = '0; data_mask = '0; data_we = 0; data_re = 0;
    inst_addr = '0; inst_re = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    arready = 1; rvalid = 0; rdata = '0; rresp = '0; rlast = 1;

    // Reset state and constant outputs
    #1;
    chk("rst_valids", {59'd0, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
    chk("rst_pulses", {61'd0, data_finish, inst_finish, bus_err}, 64'd0);
    chk("rst_rdata", data_rdata | inst_rdata, 64'd0);
    chk("const_ar", {49'd0, arid, arlen, arsize, arburst}, {49'd0, 4'd0, 8'd0, 3'b011, 2'b01});
    chk("const_aw", {49'd0, awid, awlen, awsize, awburst}, {49'd0, 4'd0, 8'd0, 3'b011, 2'b01});

    // Contention: both held, grants alternate starting with data
    @(negedge clk);
    rst = 1'b0;
    data_re = 1; data_addr = 64'h0000_0000_0000_00A0;
    inst_re = 1; inst_addr = 64'h0000_0000_0000_00B0;
    read_txn("cont0", 64'hA0, 64'h0000_0000_0000_0100, 2'b00, 1'b0);
    read_txn("cont1", 64'hB0, 64'h0000_0000_0000_0101, 2'b00, 1'b1);
    read_txn("cont2", 64'hA0, 64'h0000_0000_0000_0102, 2'b00, 1'b0);
    read_txn("cont3", 64'hB0, 64'h0000_0000_0000_0103, 2'b00, 1'b1);
    data_re = 0; inst_re = 0;
    @(negedge clk);
    chk("cont_idle", {62'd0, arvalid, awvalid}, 64'd0);

    // Single read
    data_re = 1; data_addr = 64'h0000_0000_1000_0004;
    read_txn("rd", 64'h1000_0004, 64'h1122_3344_5566_7788, 2'b00, 1'b0);
    data_re = 0;
    @(negedge clk);
    chk("rd_finish_pulse", {62'd0, data_finish, arvalid}, 64'd0);

    // Write, awready immediate, wready three cycles late
    awready = 1; wready = 0;
    data_we = 1; data_addr = 64'h0000_0000_0200_BFF8;
    data_wdata = 64'h0000_0000_DEAD_BEEF; data_mask = 8'h0F;
    @(negedge clk);
    chk("wr_valids1", {62'd0, awvalid, wvalid}, 64'd3);
    chk("wr_awaddr", {32'd0, awaddr}, 64'h0200_BFF8);
    chk("wr_wdata", wdata, 64'h0000_0000_DEAD_BEEF);
    chk("wr_wstrb_wlast", {55'd0, wstrb, wlast}, {55'd0, 8'h0F, 1'b1});
    data_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("wr_valids2", {61'd0, awvalid, wvalid, bready}, 64'b010);
    chk("wr_wdata_held", wdata, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    chk("wr_valids3", {61'd0, awvalid, wvalid, bready}, 64'b010);
    @(negedge clk);
    chk("wr_valids4", {61'd0, awvalid, wvalid, bready}, 64'b010);
    wready = 1;
    @(negedge clk);
    chk("wr_b", {61'd0, awvalid, wvalid, bready}, 64'b001);
    wready = 0; bvalid = 1;
    @(negedge clk);
    bvalid = 0;
    chk("wr_finish", {60'd0, data_finish, inst_finish, bus_err, bready}, 64'b1000);
    data_we = 0;
    @(negedge clk);
    chk("wr_finish_pulse", {63'd0, data_finish}, 64'd0);

    // Split access: address changes on finish
    data_re = 1; data_addr = 64'h0000_0000_1000_0004;
    read_txn("split0", 64'h1000_0004, 64'h0000_0000_AAAA_0004, 2'b00, 1'b0);
    data_addr = 64'h0000_0000_1000_0000;
    read_txn("split1", 64'h1000_0000, 64'h0000_0000_AAAA_0000, 2'b00, 1'b0);
    data_re = 0;
    @(negedge clk);
    chk("split_no_dup", {63'd0, arvalid}, 64'd0);

    // Read error response
    data_re = 1; data_addr = 64'h0000_0000_1000_0010;
    read_txn("err", 64'h1000_0010, 64'hCAFE_0000_0000_BEEF, 2'b10, 1'b0);
    data_re = 0;
    @(negedge clk);
    chk("err_idle", {61'd0, bus_err, data_finish, arvalid}, 64'd0);

    // Asynchronous reset while in R with rvalid pending
    data_re = 1; data_addr = 64'h0000_0000_2000_0000;
    @(negedge clk);
    chk("arst_ar", {63'd0, arvalid}, 64'd1);
    @(negedge clk);
    chk("arst_r", {63'd0, rready}, 64'd1);
    rvalid = 1; rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    #2 rst = 1'b1;
    #1;
    chk("arst_valids", {59'd0, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
    chk("arst_rdata", data_rdata, 64'd0);
    data_re = 0; rvalid = 0;
    @(negedge clk);
    chk("arst_no_finish", {62'd0, data_finish, inst_finish}, 64'd0);
    rst = 1'b0;
    data_re = 1; data_addr = 64'h0000_0000_3000_0008;
    read_txn("arst_fresh", 64'h3000_0008, 64'h0000_0000_0000_55AA, 2'b00, 1'b0);
    data_re = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
